// File: rtl/imm_gen_stage.sv
// LEGv8 immediate generator: classifies an instruction by format and extracts its
// extended immediate, presented through one valid/ready stage with a 2-entry skid buffer.
module imm_gen_stage #(
  parameter int WORD         = 64,
  parameter int INSTR_LEN    = 32,
  parameter bit BRANCH_SCALE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_imm,
  output logic [2:0]           out_fmt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_D     = 3'd1;
  localparam logic [2:0] FMT_CB    = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_I     = 3'd4;
  localparam logic [2:0] FMT_IM    = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WORD-1:0]  out_imm_q, out_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d;
  logic [WORD-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic [WORD-1:0]  dec_imm_s;
  logic [2:0]       dec_fmt_s;
  logic             accept_s;
  logic             pop_s;

  // Priority-ordered format match; the first matching opcode group wins.
  function automatic void decode_instr(input  logic [31:0]     ins,
                                       output logic [2:0]      fmt,
                                       output logic [WORD-1:0] imm);
    logic [WORD-1:0] ext;
    ext = {WORD{1'b0}};
    if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
      fmt = FMT_D;
      imm = {{(WORD-9){ins[20]}}, ins[20:12]};
    end else if (ins[31:24] == 8'b10110100 || ins[31:24] == 8'b10110101 ||
                 ins[31:24] == 8'b01010100) begin
      fmt = FMT_CB;
      ext = {{(WORD-19){ins[23]}}, ins[23:5]};
      imm = BRANCH_SCALE ? (ext << 2'd2) : ext;
    end else if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      fmt = FMT_B;
      ext = {{(WORD-26){ins[25]}}, ins[25:0]};
      imm = BRANCH_SCALE ? (ext << 2'd2) : ext;
    end else if (ins[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100,
                                    10'b1111000100, 10'b1001001000, 10'b1111001000,
                                    10'b1011001000, 10'b1101001000}) begin
      fmt = FMT_I;
      imm = {{(WORD-12){1'b0}}, ins[21:10]};
    end else if (ins[31:23] == 9'b110100101 || ins[31:23] == 9'b111100101) begin
      // Shift amounts of WORD or more clear the result, dropping upper half-words.
      fmt = FMT_IM;
      imm = {{(WORD-16){1'b0}}, ins[20:5]} << {ins[22:21], 4'b0000};
    end else if (ins[31:21] == 11'b11010011011 || ins[31:21] == 11'b11010011010) begin
      fmt = FMT_SHAMT;
      imm = {{(WORD-6){1'b0}}, ins[15:10]};
    end else begin
      fmt = FMT_NONE;
      imm = {WORD{1'b0}};
    end
  endfunction

  // Combinational decode of the offered instruction.
  always_comb begin
    dec_fmt_s = FMT_NONE;
    dec_imm_s = {WORD{1'b0}};
    decode_instr(in_instr[31:0], dec_fmt_s, dec_imm_s);
  end

  assign accept_s = in_valid && in_ready_q;
  assign pop_s    = out_valid_q && out_ready;

  // Occupancy next-state and datapath steering; data only moves on a transfer.
  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept_s) begin
            state_d   = OCC_ONE;
            out_imm_d = dec_imm_s;
            out_fmt_d = dec_fmt_s;
          end else begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept_s && pop_s) begin
            state_d   = OCC_ONE;
            out_imm_d = dec_imm_s;
            out_fmt_d = dec_fmt_s;
          end else if (accept_s) begin
            state_d    = OCC_FULL;
            skid_imm_d = dec_imm_s;
            skid_fmt_d = dec_fmt_s;
          end else if (pop_s) begin
            state_d = OCC_EMPTY;
          end else begin
            state_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (pop_s) begin
            state_d   = OCC_ONE;
            out_imm_d = skid_imm_q;
            out_fmt_d = skid_fmt_q;
          end else begin
            state_d = OCC_FULL;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
        end
      endcase
    end
    out_valid_d = (state_d != OCC_EMPTY);
    in_ready_d  = (state_d != OCC_FULL);
  end

  // Stage registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_imm_q   <= {WORD{1'b0}};
      out_fmt_q   <= FMT_NONE;
      skid_imm_q  <= {WORD{1'b0}};
      skid_fmt_q  <= FMT_NONE;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_imm_q   <= out_imm_d;
      out_fmt_q   <= out_fmt_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_fmt   = out_fmt_q;

endmodule
